// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths and forward-stage state encoding for the output neuron
package nn_pkg;

    localparam int HID_W = 10;
    localparam int WGT_W = 8;
    localparam int ACC_W = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } fwd_state_t;

endpackage

// File: rtl/sat_mac.sv
// rtl/sat_mac.sv - combinational unsigned acc + a*b with saturation at ACC_W bits
module sat_mac #(
    parameter int A_W   = nn_pkg::HID_W,
    parameter int B_W   = nn_pkg::WGT_W,
    parameter int ACC_W = nn_pkg::ACC_W
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    localparam int PROD_W = A_W + B_W;
    // Sum is one bit wider than the wider operand so any carry past ACC_W is visible.
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;

    // Multiply, widen, add, then clamp to all-ones if anything spilled above ACC_W.
    always_comb begin
        prod  = a_i * b_i;
        sum   = SUM_W'(acc_i) + SUM_W'(prod);
        ovf_o = |sum[SUM_W-1:ACC_W];
        sum_o = ovf_o ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/output_forward.sv
// rtl/output_forward.sv - serial snapshot-and-MAC forward pass for the output neuron
module output_forward #(
    parameter int  N_HIDDEN = 4,
    parameter int  HID_W    = nn_pkg::HID_W,
    parameter int  WGT_W    = nn_pkg::WGT_W,
    parameter int  ACC_W    = nn_pkg::ACC_W,
    localparam int SEL_W    = $clog2(N_HIDDEN)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      clear_i,
    input  logic [N_HIDDEN*HID_W-1:0] hidden_i,
    input  logic [N_HIDDEN*WGT_W-1:0] weights_i,
    input  logic [SEL_W-1:0]          hsel_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ACC_W-1:0]          final_o,
    output logic [HID_W-1:0]          hidden_val_o,
    output logic                      ovf_o
);

    import nn_pkg::*;

    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_HIDDEN - 1);

    fwd_state_t       state_q, state_d;
    logic [SEL_W-1:0] idx_q;
    logic [HID_W-1:0] hid_q [N_HIDDEN];
    logic [WGT_W-1:0] wgt_q [N_HIDDEN];
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] final_q;
    logic             ovf_q;
    logic [ACC_W-1:0] mac_sum;
    logic             mac_ovf;
    logic             idx_last;

    assign idx_last = (idx_q == IDX_LAST);

    sat_mac #(
        .A_W   (HID_W),
        .B_W   (WGT_W),
        .ACC_W (ACC_W)
    ) u_sat_mac (
        .acc_i (acc_q),
        .a_i   (hid_q[idx_q]),
        .b_i   (wgt_q[idx_q]),
        .sum_o (mac_sum),
        .ovf_o (mac_ovf)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over everything, start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = LOAD;
                LOAD:    state_d = MAC;
                MAC:     if (idx_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Snapshot, accumulator, index and result; clear keeps the snapshot intact.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_HIDDEN; k++) begin
                hid_q[k] <= '0;
                wgt_q[k] <= '0;
            end
            acc_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            final_q <= '0;
        end else if (clear_i) begin
            acc_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            final_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    for (int k = 0; k < N_HIDDEN; k++) begin
                        hid_q[k] <= hidden_i[k*HID_W +: HID_W];
                        wgt_q[k] <= weights_i[k*WGT_W +: WGT_W];
                    end
                    acc_q <= '0;
                    idx_q <= '0;
                    ovf_q <= 1'b0;
                end
                MAC: begin
                    acc_q <= mac_sum;
                    ovf_q <= ovf_q | mac_ovf;
                    idx_q <= idx_q + SEL_W'(1);
                    // Result is published only on the final term so backprop never sees partials.
                    if (idx_last) begin
                        final_q <= mac_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs and snapshot read port; out-of-range selects read as zero.
    always_comb begin
        busy_o       = (state_q == LOAD) || (state_q == MAC);
        done_o       = (state_q == DONE) && !clear_i;
        final_o      = final_q;
        ovf_o        = ovf_q;
        hidden_val_o = '0;
        if (32'(hsel_i) < N_HIDDEN) begin
            hidden_val_o = hid_q[hsel_i];
        end
    end

endmodule

// File: tb/tb_output_forward.sv
// tb/tb_output_forward.sv - directed self-checking bench for output_forward
module tb_output_forward;

    localparam int N  = 4;
    localparam int HW = 10;
    localparam int WW = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic            clear_i;
    logic [N*HW-1:0] hidden_i;
    logic [N*WW-1:0] weights_i;
    logic [1:0]      hsel_i;
    logic            busy_o, done_o, ovf_o;
    logic [22:0]     final_o;
    logic [HW-1:0]   hidden_val_o;
    logic            s_busy_o, s_done_o, s_ovf_o;
    logic [17:0]     s_final_o;
    logic [HW-1:0]   s_hidden_val_o;

    int checks   = 0;
    int failures = 0;

    output_forward #(.N_HIDDEN(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .hidden_i(hidden_i), .weights_i(weights_i), .hsel_i(hsel_i),
        .busy_o(busy_o), .done_o(done_o), .final_o(final_o),
        .hidden_val_o(hidden_val_o), .ovf_o(ovf_o)
    );

    output_forward #(.N_HIDDEN(N), .ACC_W(18)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .hidden_i(hidden_i), .weights_i(weights_i), .hsel_i(hsel_i),
        .busy_o(s_busy_o), .done_o(s_done_o), .final_o(s_final_o),
        .hidden_val_o(s_hidden_val_o), .ovf_o(s_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_basic();
        hidden_i  = {10'd4, 10'd3, 10'd2, 10'd1};
        weights_i = {8'd8, 8'd7, 8'd6, 8'd5};
    endtask

    // Launches one pass and observes a fixed window; lat is the cycle of the first done pulse.
    task automatic run_pass(output int lat, output int busy_cnt, output int done_cnt);
        lat = -1; busy_cnt = 0; done_cnt = 0;
        start_i = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 1) start_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                if (lat < 0) lat = n;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; hsel_i = 2'd0;
        hidden_i = '0; weights_i = '0;
        tick(); tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done_o); end
        checks++; if (final_o !== 23'd0) begin failures++; $display("FAIL reset_final got=%0d exp=0", final_o); end
        checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf_o); end
        checks++; if (hidden_val_o !== 10'd0) begin failures++; $display("FAIL reset_hval got=%0d exp=0", hidden_val_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        set_basic();
        run_pass(lat, bc, dc);
        checks++; if (lat !== 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", lat); end
        checks++; if (bc !== 5) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
        checks++; if (final_o !== 23'd70) begin failures++; $display("FAIL basic_final got=%0d exp=70", final_o); end
        checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0b exp=0", ovf_o); end
        hsel_i = 2'd2;
        #1;
        checks++; if (hidden_val_o !== 10'd3) begin failures++; $display("FAIL basic_hval2 got=%0d exp=3", hidden_val_o); end
    endtask

    task automatic test_reset_mid_mac();
        int lat, bc, dc;
        set_basic();
        hsel_i = 2'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy_o); end
        checks++; if (final_o !== 23'd0) begin failures++; $display("FAIL rstmid_final got=%0d exp=0", final_o); end
        checks++; if (hidden_val_o !== 10'd0) begin failures++; $display("FAIL rstmid_hval got=%0d exp=0", hidden_val_o); end
        tick();
        rst_i = 1'b0;
        tick();
        run_pass(lat, bc, dc);
        checks++; if (lat !== 6) begin failures++; $display("FAIL rstmid_latency got=%0d exp=6", lat); end
        checks++; if (final_o !== 23'd70) begin failures++; $display("FAIL rstmid_final_after got=%0d exp=70", final_o); end
    endtask

    task automatic test_max();
        int lat, bc, dc;
        hidden_i  = {N{10'd1023}};
        weights_i = {N{8'd255}};
        run_pass(lat, bc, dc);
        checks++; if (final_o !== 23'd1043460) begin failures++; $display("FAIL max_final got=%0d exp=1043460", final_o); end
        checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL max_ovf got=%0b exp=0", ovf_o); end
        hsel_i = 2'd3;
        #1;
        checks++; if (hidden_val_o !== 10'd1023) begin failures++; $display("FAIL max_hval3 got=%0d exp=1023", hidden_val_o); end
        checks++; if (s_final_o !== 18'd262143) begin failures++; $display("FAIL sat_final got=%0d exp=262143", s_final_o); end
        checks++; if (s_ovf_o !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", s_ovf_o); end
    endtask

    task automatic test_snapshot();
        int dc;
        dc = 0;
        set_basic();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        hidden_i = '0;
        start_i  = 1'b1;
        tick();
        if (done_o) dc++;
        start_i = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done_o) dc++;
        end
        checks++; if (final_o !== 23'd70) begin failures++; $display("FAIL snap_final got=%0d exp=70", final_o); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL snap_done_count got=%0d exp=1", dc); end
        checks++; if (s_ovf_o !== 1'b0) begin failures++; $display("FAIL snap_sat_ovf_cleared got=%0b exp=0", s_ovf_o); end
    endtask

    task automatic test_clear();
        int dc;
        dc = 0;
        set_basic();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        clear_i = 1'b1;
        tick();
        if (done_o) dc++;
        clear_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clear_busy got=%0b exp=0", busy_o); end
        checks++; if (final_o !== 23'd0) begin failures++; $display("FAIL clear_final got=%0d exp=0", final_o); end
        hsel_i = 2'd1;
        #1;
        checks++; if (hidden_val_o !== 10'd2) begin failures++; $display("FAIL clear_snapshot_kept got=%0d exp=2", hidden_val_o); end
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done_o) dc++;
        end
        checks++; if (dc !== 0) begin failures++; $display("FAIL clear_no_done got=%0d exp=0", dc); end
        clear_i = 1'b1;
        start_i = 1'b1;
        tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clear_start_idle got=%0b exp=0", busy_o); end
        clear_i = 1'b0;
        start_i = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clear_start_idle2 got=%0b exp=0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_mac();
        test_max();
        test_snapshot();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
